adder_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one WIDTH-bit adder between NUM_REQ requesters.
- Grants one requester at a time, captures its operands, registers {carry, sum], and holds a response with the requester ID until it is acknowledged.
- Sits between the requester-side stimulus interfaces and the single adder datapath in the adder verification environment.

---
 rtl/adder_arbiter_if.sv | 28 ++
 rtl/adder_arbiter.sv | 143 ++++++++++++++
 tb/tb_adder_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_arbiter_if.sv
// Requester-side bus of the shared-adder arbiter: request/operand lanes,
// grant, and the registered response with its acknowledge.
interface adder_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] a_in;
    logic [NUM_REQ*WIDTH-1:0] b_in;
    logic [NUM_REQ-1:0]       gnt;
    logic [WIDTH-1:0]         sum_out;
    logic                     carry_out;
    logic                     rsp_valid;
    logic [ID_W-1:0]          rsp_id;
    logic                     rsp_ack;
    logic                     busy;

    modport master (
        output req, a_in, b_in, rsp_ack,
        input  gnt, sum_out, carry_out, rsp_valid, rsp_id, busy
    );

    modport slave (
        input  req, a_in, b_in, rsp_ack,
        output gnt, sum_out, carry_out, rsp_valid, rsp_id, busy
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder between NUM_REQ requesters;
// each operation is grant -> add -> response held until acknowledged.
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic           clk,
    input  logic           rst,
    adder_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_grant;
    logic                 w_calc;
    logic                 w_release;

    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      r_idx;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_carry;
    logic                 r_rsp_valid;
    logic [ID_W-1:0]      r_rsp_id;

    // Requests rotated so that bit k is requester (ptr + k) mod NUM_REQ;
    // the lowest set bit of the rotated vector is the round-robin winner.
    logic [NUM_REQ-1:0]             w_req_rot;
    logic [NUM_REQ-1:0]             w_first;
    logic [NUM_REQ:0]               w_seen;
    logic [NUM_REQ:0][ID_W-1:0]     w_off_chain;
    logic [ID_W-1:0]                w_off;
    logic                           w_any;
    logic [ID_W:0]                  w_win_ext;
    logic [ID_W-1:0]                w_win;
    logic [ID_W:0]                  w_ptr_ext;
    logic [ID_W-1:0]                w_ptr_next;
    logic [WIDTH-1:0]               w_a [NUM_REQ];
    logic [WIDTH-1:0]               w_b [NUM_REQ];

    assign w_req_rot      = NUM_REQ'({bus.req, bus.req} >> r_ptr);
    assign w_seen[0]      = 1'b0;
    assign w_off_chain[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign w_first[gi]        = w_req_rot[gi] & ~w_seen[gi];
            assign w_seen[gi+1]       = w_seen[gi] | w_req_rot[gi];
            assign w_off_chain[gi+1]  = w_off_chain[gi] | (w_first[gi] ? ID_W'(gi) : '0);
            assign w_a[gi]            = bus.a_in[gi*WIDTH +: WIDTH];
            assign w_b[gi]            = bus.b_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_off     = w_off_chain[NUM_REQ];
    assign w_any     = w_seen[NUM_REQ];

    // Undo the rotation: winner = (ptr + offset) mod NUM_REQ, computed one bit wider.
    assign w_win_ext = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win     = (w_win_ext >= (ID_W+1)'(NUM_REQ)) ?
                       ID_W'(w_win_ext - (ID_W+1)'(NUM_REQ)) : w_win_ext[ID_W-1:0];
    assign w_ptr_ext = {1'b0, w_win} + (ID_W+1)'(1);
    assign w_ptr_next = (w_ptr_ext >= (ID_W+1)'(NUM_REQ)) ?
                        ID_W'(w_ptr_ext - (ID_W+1)'(NUM_REQ)) : w_ptr_ext[ID_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_calc       = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_next = CALC;
                    w_grant      = 1'b1;
                end
            end
            CALC: begin
                w_state_next = RESP;
                w_calc       = 1'b1;
            end
            RESP: begin
                if (bus.rsp_ack) begin
                    w_state_next = IDLE;
                    w_release    = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_idx       <= '0;
            r_gnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            // Grant is only ever asserted for the single CALC cycle.
            r_gnt <= w_grant ? (NUM_REQ'(1) << w_win) : '0;
            if (w_grant) begin
                r_a   <= w_a[w_win];
                r_b   <= w_b[w_win];
                r_idx <= w_win;
                r_ptr <= w_ptr_next;
            end
            if (w_calc) begin
                {r_carry, r_sum} <= {1'b0, r_a} + {1'b0, r_b};
                r_rsp_id         <= r_idx;
                r_rsp_valid      <= 1'b1;
            end else if (w_release) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.sum_out   = r_sum;
    assign bus.carry_out = r_carry;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus randomized
// operations checked against a transaction-level round-robin model.
module tb_adder_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   m_ptr = 0;

    adder_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus_if ();

    adder_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Round-robin rule: first set request scanning upward from the pointer, wrapping.
    function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = (p + k) % NUM_REQ;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus_if.a_in[i*WIDTH +: WIDTH] = a;
        bus_if.b_in[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic apply_reset();
        bus_if.req     = '0;
        bus_if.rsp_ack = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus_if.req     = '0;
        bus_if.a_in    = '0;
        bus_if.b_in    = '0;
        bus_if.rsp_ack = 1'b0;
        #2;
        total++; if (bus_if.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", bus_if.gnt); end
        total++; if (bus_if.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus_if.rsp_valid); end
        total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
        total++; if ({bus_if.carry_out, bus_if.sum_out, bus_if.rsp_id} !== 7'd0) begin
            bad++; $display("FAIL reset_data: got c=%b s=%0d id=%0d want zeros", bus_if.carry_out, bus_if.sum_out, bus_if.rsp_id);
        end
        tick();
        tick();
        rst = 1'b0;
        m_ptr = 0;
        tick();
        total++; if (bus_if.busy !== 1'b0 || bus_if.gnt !== 4'b0000) begin
            bad++; $display("FAIL idle_no_req: got busy=%b gnt=%b want 0/0000", bus_if.busy, bus_if.gnt);
        end
        $display("reset: outputs cleared, idle with no request");
    endtask

    task automatic test_single();
        int                 ids [2] = '{0, 2};
        logic [WIDTH-1:0]   as  [2] = '{4'd10, 4'd12};
        logic [WIDTH-1:0]   bs  [2] = '{4'd5, 4'd7};
        bus_if.rsp_ack = 1'b1;
        for (int n = 0; n < 2; n++) begin
            logic [WIDTH:0]     e;
            logic [NUM_REQ-1:0] eg;
            e  = {1'b0, as[n]} + {1'b0, bs[n]};
            eg = NUM_REQ'(1) << ids[n];
            set_op(ids[n], as[n], bs[n]);
            bus_if.req = eg;
            tick();
            total++; if (bus_if.gnt !== eg || bus_if.busy !== 1'b1) begin
                bad++; $display("FAIL single_gnt: got gnt=%b busy=%b want %b/1", bus_if.gnt, bus_if.busy, eg);
            end
            m_ptr = (ids[n] + 1) % NUM_REQ;
            bus_if.req = '0;
            tick();
            total++; if (bus_if.rsp_valid !== 1'b1 || bus_if.gnt !== 4'b0000) begin
                bad++; $display("FAIL single_valid: got v=%b gnt=%b want 1/0000", bus_if.rsp_valid, bus_if.gnt);
            end
            total++; if ({bus_if.carry_out, bus_if.sum_out} !== e || bus_if.rsp_id !== ID_W'(ids[n])) begin
                bad++; $display("FAIL single_result: got c=%b s=%0d id=%0d want c=%b s=%0d id=%0d",
                                bus_if.carry_out, bus_if.sum_out, bus_if.rsp_id, e[WIDTH], e[WIDTH-1:0], ids[n]);
            end
            tick();
            total++; if (bus_if.rsp_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
                bad++; $display("FAIL single_release: got v=%b busy=%b want 0/0", bus_if.rsp_valid, bus_if.busy);
            end
            $display("single: req %0d %0d+%0d -> c=%b s=%0d", ids[n], as[n], bs[n], bus_if.carry_out, bus_if.sum_out);
        end
        bus_if.rsp_ack = 1'b0;
    endtask

    task automatic test_round_robin();
        int w;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, WIDTH'(i), 4'd1);
        bus_if.rsp_ack = 1'b1;
        bus_if.req     = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            w = pick(bus_if.req, m_ptr);
            total++; if (bus_if.gnt !== (NUM_REQ'(1) << w)) begin
                bad++; $display("FAIL rr_gnt[%0d]: got %b want requester %0d", n, bus_if.gnt, w);
            end
            m_ptr = (w + 1) % NUM_REQ;
            if (n == 4) bus_if.req = '0;
            tick();
            total++; if (bus_if.rsp_valid !== 1'b1 || bus_if.sum_out !== WIDTH'(w + 1) || bus_if.rsp_id !== ID_W'(w)) begin
                bad++; $display("FAIL rr_result[%0d]: got v=%b s=%0d id=%0d want 1/%0d/%0d",
                                n, bus_if.rsp_valid, bus_if.sum_out, bus_if.rsp_id, w + 1, w);
            end
            tick();
            total++; if (bus_if.rsp_valid !== 1'b0 || bus_if.gnt !== 4'b0000) begin
                bad++; $display("FAIL rr_gap[%0d]: got v=%b gnt=%b want 0/0000", n, bus_if.rsp_valid, bus_if.gnt);
            end
            $display("round_robin: grant %0d sum %0d", w, bus_if.sum_out);
        end
        bus_if.rsp_ack = 1'b0;
    endtask

    task automatic test_hold();
        set_op(0, 4'd6, 4'd4);
        set_op(1, 4'd3, 4'd3);
        bus_if.rsp_ack = 1'b0;
        bus_if.req     = 4'b0001;
        tick();
        total++; if (bus_if.gnt !== 4'b0001) begin bad++; $display("FAIL hold_gnt0: got %b want 0001", bus_if.gnt); end
        m_ptr = 1;
        bus_if.req = 4'b0010;
        tick();
        for (int c = 0; c < 5; c++) begin
            total++; if (bus_if.rsp_valid !== 1'b1 || bus_if.sum_out !== 4'd10 || bus_if.rsp_id !== 2'd0 || bus_if.gnt !== 4'b0000) begin
                bad++; $display("FAIL hold_stable[%0d]: got v=%b s=%0d id=%0d gnt=%b want 1/10/0/0000",
                                c, bus_if.rsp_valid, bus_if.sum_out, bus_if.rsp_id, bus_if.gnt);
            end
            tick();
        end
        bus_if.rsp_ack = 1'b1;
        tick();
        total++; if (bus_if.rsp_valid !== 1'b0 || bus_if.gnt !== 4'b0000 || bus_if.busy !== 1'b0) begin
            bad++; $display("FAIL hold_release: got v=%b gnt=%b busy=%b want 0/0000/0", bus_if.rsp_valid, bus_if.gnt, bus_if.busy);
        end
        bus_if.rsp_ack = 1'b0;
        tick();
        total++; if (bus_if.gnt !== 4'b0010) begin bad++; $display("FAIL hold_pending_gnt: got %b want 0010", bus_if.gnt); end
        m_ptr = 2;
        bus_if.req = '0;
        tick();
        total++; if (bus_if.sum_out !== 4'd6 || bus_if.rsp_id !== 2'd1) begin
            bad++; $display("FAIL hold_pending_result: got s=%0d id=%0d want 6/1", bus_if.sum_out, bus_if.rsp_id);
        end
        bus_if.rsp_ack = 1'b1;
        tick();
        bus_if.rsp_ack = 1'b0;
        $display("hold: response held 5 cycles, pending requester 1 served next");
    endtask

    task automatic test_ack_idle();
        bus_if.rsp_ack = 1'b1;
        bus_if.req     = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if (bus_if.rsp_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
                bad++; $display("FAIL ack_idle[%0d]: got v=%b busy=%b want 0/0", c, bus_if.rsp_valid, bus_if.busy);
            end
        end
        set_op(1, 4'd15, 4'd15);
        bus_if.req = 4'b0010;
        tick();
        total++; if (bus_if.gnt !== 4'b0010) begin bad++; $display("FAIL ack_idle_gnt: got %b want 0010", bus_if.gnt); end
        m_ptr = 2;
        bus_if.req = '0;
        tick();
        total++; if (bus_if.rsp_valid !== 1'b1 || bus_if.sum_out !== 4'd14 || bus_if.carry_out !== 1'b1) begin
            bad++; $display("FAIL ack_idle_result: got v=%b s=%0d c=%b want 1/14/1", bus_if.rsp_valid, bus_if.sum_out, bus_if.carry_out);
        end
        tick();
        total++; if (bus_if.rsp_valid !== 1'b0) begin bad++; $display("FAIL ack_idle_release: got %b want 0", bus_if.rsp_valid); end
        bus_if.rsp_ack = 1'b0;
        $display("ack_idle: 15+15 -> c=1 s=14");
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] pend = '0;
        logic [NUM_REQ-1:0] newbits;
        logic [WIDTH-1:0]   ma [NUM_REQ];
        logic [WIDTH-1:0]   mb [NUM_REQ];
        logic [WIDTH:0]     e;
        int                 w;
        int                 d;
        for (int op = 0; op < 40; op++) begin
            newbits = NUM_REQ'($urandom_range(1, 15));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (newbits[i] && !pend[i]) begin
                    ma[i] = WIDTH'($urandom);
                    mb[i] = WIDTH'($urandom);
                    set_op(i, ma[i], mb[i]);
                end
            end
            pend           = pend | newbits;
            bus_if.req     = pend;
            bus_if.rsp_ack = 1'($urandom_range(0, 1));
            tick();
            w = pick(pend, m_ptr);
            e = {1'b0, ma[w]} + {1'b0, mb[w]};
            total++; if (bus_if.gnt !== (NUM_REQ'(1) << w)) begin
                bad++; $display("FAIL rand_gnt[%0d]: got %b want requester %0d", op, bus_if.gnt, w);
            end
            m_ptr   = (w + 1) % NUM_REQ;
            pend[w] = 1'b0;
            bus_if.req = pend;
            set_op(w, WIDTH'($urandom), WIDTH'($urandom));
            bus_if.rsp_ack = 1'($urandom_range(0, 1));
            tick();
            total++; if (bus_if.rsp_valid !== 1'b1 || {bus_if.carry_out, bus_if.sum_out} !== e || bus_if.rsp_id !== ID_W'(w)) begin
                bad++; $display("FAIL rand_result[%0d]: got v=%b c=%b s=%0d id=%0d want 1/%b/%0d/%0d",
                                op, bus_if.rsp_valid, bus_if.carry_out, bus_if.sum_out, bus_if.rsp_id, e[WIDTH], e[WIDTH-1:0], w);
            end
            bus_if.rsp_ack = 1'b0;
            d = $urandom_range(0, 3);
            for (int c = 0; c < d; c++) begin
                tick();
                total++; if (bus_if.rsp_valid !== 1'b1 || {bus_if.carry_out, bus_if.sum_out} !== e || bus_if.gnt !== 4'b0000) begin
                    bad++; $display("FAIL rand_hold[%0d]: got v=%b c=%b s=%0d gnt=%b want 1/%b/%0d/0000",
                                    op, bus_if.rsp_valid, bus_if.carry_out, bus_if.sum_out, bus_if.gnt, e[WIDTH], e[WIDTH-1:0]);
                end
            end
            bus_if.rsp_ack = 1'b1;
            tick();
            total++; if (bus_if.rsp_valid !== 1'b0 || bus_if.gnt !== 4'b0000 || bus_if.rsp_id !== ID_W'(w)) begin
                bad++; $display("FAIL rand_release[%0d]: got v=%b gnt=%b id=%0d want 0/0000/%0d",
                                op, bus_if.rsp_valid, bus_if.gnt, bus_if.rsp_id, w);
            end
            bus_if.rsp_ack = 1'b0;
            $display("random %0d: grant %0d %0d+%0d -> c=%b s=%0d ack_delay=%0d", op, w, ma[w], mb[w], e[WIDTH], e[WIDTH-1:0], d);
        end
        bus_if.req = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        set_op(3, 4'd9, 4'd9);
        bus_if.rsp_ack = 1'b0;
        bus_if.req     = 4'b1000;
        tick();
        total++; if (bus_if.gnt !== 4'b1000) begin bad++; $display("FAIL rmid_gnt3: got %b want 1000", bus_if.gnt); end
        bus_if.req = '0;
        tick();
        total++; if (bus_if.rsp_valid !== 1'b1 || bus_if.sum_out !== 4'd2) begin
            bad++; $display("FAIL rmid_resp: got v=%b s=%0d want 1/2", bus_if.rsp_valid, bus_if.sum_out);
        end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus_if.rsp_valid !== 1'b0 || bus_if.sum_out !== 4'd0 || bus_if.busy !== 1'b0 || bus_if.gnt !== 4'b0000) begin
            bad++; $display("FAIL rmid_async: got v=%b s=%0d busy=%b gnt=%b want 0/0/0/0000",
                            bus_if.rsp_valid, bus_if.sum_out, bus_if.busy, bus_if.gnt);
        end
        tick();
        rst   = 1'b0;
        m_ptr = 0;
        set_op(0, 4'd1, 4'd2);
        bus_if.req     = 4'b1001;
        bus_if.rsp_ack = 1'b1;
        tick();
        total++; if (bus_if.gnt !== 4'b0001) begin bad++; $display("FAIL rmid_ptr_reset: got %b want 0001", bus_if.gnt); end
        bus_if.req = 4'b1000;
        tick();
        total++; if (bus_if.sum_out !== 4'd3 || bus_if.rsp_id !== 2'd0) begin
            bad++; $display("FAIL rmid_result: got s=%0d id=%0d want 3/0", bus_if.sum_out, bus_if.rsp_id);
        end
        tick();
        tick();
        total++; if (bus_if.gnt !== 4'b1000) begin bad++; $display("FAIL rmid_next_gnt: got %b want 1000", bus_if.gnt); end
        bus_if.req = '0;
        tick();
        tick();
        bus_if.rsp_ack = 1'b0;
        $display("reset_mid: async clear in RESP, pointer restarted at 0");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_ack_idle();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
